// File: rtl/pad_stream_if.sv
// pad_stream_if -- stream bundle for the zero-padding inserter.
//   Data_In / Valid_In   : pooled pixel stream into the padder (no backpressure)
//   Data_Out / Valid_Out : padded raster out of the padder
//   Frame_Done           : pulse on the last padded pixel of a frame
//   Overflow             : sticky FIFO overflow flag
//   Pad_Value            : border pixel value, only when PAD_STREAM_PAD_VALUE_EN
// Modports: slave = padder side, master = producer/consumer side.
interface pad_stream_if #(
   parameter int DATA_WIDHT = 32
);
   logic [DATA_WIDHT-1:0] Data_In;
   logic                  Valid_In;
   logic [DATA_WIDHT-1:0] Data_Out;
   logic                  Valid_Out;
   logic                  Frame_Done;
   logic                  Overflow;
`ifdef PAD_STREAM_PAD_VALUE_EN
   logic [DATA_WIDHT-1:0] Pad_Value;

   modport slave  (input  Data_In, Valid_In, Pad_Value,
                   output Data_Out, Valid_Out, Frame_Done, Overflow);
   modport master (output Data_In, Valid_In, Pad_Value,
                   input  Data_Out, Valid_Out, Frame_Done, Overflow);
`else
   modport slave  (input  Data_In, Valid_In,
                   output Data_Out, Valid_Out, Frame_Done, Overflow);
   modport master (output Data_In, Valid_In,
                   input  Data_Out, Valid_Out, Frame_Done, Overflow);
`endif
endinterface

// File: rtl/pad_stream.sv
// pad_stream -- zero-padding inserter behind the 2x2 max-pool stage.
// Takes an IMG_WIDHT x IMG_HEIGHT pooled raster (sparse, no backpressure),
// buffers data pixels in a FIFO and emits an (IMG_WIDHT+2*PAD) x
// (IMG_HEIGHT+2*PAD) raster with a PAD-pixel border.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : pad_stream_if.slave (Data_In/Valid_In in; Data_Out/Valid_Out,
//          Frame_Done, Overflow out -- all outputs registered)
// Optional: define PAD_STREAM_PAD_VALUE_EN to add bus.Pad_Value; border
// pixels then carry Pad_Value (sampled at emission) instead of 0.
// Sizing: FIFO_DEPTH should be >= OW*PAD + PAD + 2 for 1-pixel-per-cycle
// input bursts; normal pool output rate needs far less.
module pad_stream #(
   parameter int DATA_WIDHT = 32,
   parameter int IMG_WIDHT  = 110,
   parameter int IMG_HEIGHT = 110,
   parameter int PAD        = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   pad_stream_if.slave bus
);
   localparam int OW = IMG_WIDHT + 2 * PAD;
   localparam int OH = IMG_HEIGHT + 2 * PAD;
   localparam int CW = $clog2(OW);
   localparam int RW = $clog2(OH);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] COL_LO   = CW'(PAD);
   localparam logic [CW-1:0] COL_HI   = CW'(PAD + IMG_WIDHT);
   localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
   localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
   localparam logic [RW-1:0] ROW_HI   = RW'(PAD + IMG_HEIGHT);
   localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   // ---------------- data FIFO ----------------
   logic [DATA_WIDHT-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic                  empty, full, push, pop;
   logic [DATA_WIDHT-1:0] rd_data;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop in the same cycle frees a slot, so push into a full FIFO is fine then.
   assign push    = bus.Valid_In && (!full || pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.Data_In;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         bus.Overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (bus.Valid_In && full && !pop) bus.Overflow <= 1'b1;
      end
   end

   // ---------------- FSM ----------------
   state_t          state, state_nx;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic            is_data, emit, last;
   logic [DATA_WIDHT-1:0] pad_val;

`ifdef PAD_STREAM_PAD_VALUE_EN
   assign pad_val = bus.Pad_Value;
`else
   assign pad_val = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!empty)      state_nx = RUN;
         RUN:     if (emit && last) state_nx = IDLE;
         default:                  state_nx = IDLE;
      endcase
   end

   always_comb begin
      is_data = (row >= ROW_LO) && (row < ROW_HI) && (col >= COL_LO) && (col < COL_HI);
      last    = (row == ROW_LAST) && (col == COL_LAST);
      // Border pixels never wait; data pixels wait for the FIFO.
      emit    = (state == RUN) && (!is_data || !empty);
      pop     = (state == RUN) && is_data && !empty;
   end

   // Raster position of the next pixel to emit; moves only on emission.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (emit) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Output register; Data_Out holds across stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.Data_Out   <= '0;
         bus.Valid_Out  <= 1'b0;
         bus.Frame_Done <= 1'b0;
      end else begin
         bus.Valid_Out  <= emit;
         bus.Frame_Done <= emit && last;
         if (emit) bus.Data_Out <= is_data ? rd_data : pad_val;
      end
   end
endmodule

// File: tb/tb_pad_stream.sv
// tb_pad_stream -- scoreboard bench for pad_stream.
// DUT a: 2x2 image, PAD=1, FIFO 16 (frame, sparse, back-to-back, reset).
// DUT b: 8x2 image, PAD=1, FIFO 4 (overflow).
module tb_pad_stream;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pad_stream_if #(.DATA_WIDHT(32)) if_a ();
   pad_stream_if #(.DATA_WIDHT(32)) if_b ();

   pad_stream #(.DATA_WIDHT(32), .IMG_WIDHT(2), .IMG_HEIGHT(2), .PAD(1), .FIFO_DEPTH(16))
      u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   pad_stream #(.DATA_WIDHT(32), .IMG_WIDHT(8), .IMG_HEIGHT(2), .PAD(1), .FIFO_DEPTH(4))
      u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

`ifdef PAD_STREAM_PAD_VALUE_EN
   localparam logic [31:0] PADV = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] PADV = 32'h0;
`endif

   logic [32:0] exp_q [$];   // {frame_done, data}
   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int fd_seen = 0;
   int first_edge = 0;
   bit mon_en = 1'b1;
   bit want_first = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected padded 4x4 frame around a 2x2 image a b / c d.
   task automatic push_frame(input logic [31:0] a, b, c, d);
      logic [31:0] dv [4];
      logic        fd;
      dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 4; k++) begin
            fd = (r == 3 && k == 3);
            if (r >= 1 && r <= 2 && k >= 1 && k <= 2) exp_q.push_back({fd, dv[(r-1)*2 + (k-1)]});
            else                                      exp_q.push_back({fd, PADV});
         end
   endtask

   task automatic burst_a(input int base, input int n, input bit mark);
      @(posedge clk); #1;
      if (mark) begin first_edge = cyc + 1; want_first = 1'b1; end
      for (int i = 0; i < n; i++) begin
         if_a.Data_In = 32'(base + i); if_a.Valid_In = 1'b1;
         @(posedge clk); #1;
      end
      if_a.Valid_In = 1'b0;
   endtask

   task automatic burst_b(input int base, input int n);
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if_b.Data_In = 32'(base + i); if_b.Valid_In = 1'b1;
         @(posedge clk); #1;
      end
      if_b.Valid_In = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int k = 0;
      while (exp_q.size() != 0 && k < bound) begin @(negedge clk); k++; end
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic idle_check(input string name);
      int vc = 0;
      repeat (100) begin @(negedge clk); if (if_a.Valid_Out) vc++; end
      check(name, 32'(vc), 32'd0);
   endtask

   task automatic monitor();
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (if_a.Frame_Done) fd_seen++;
         if (mon_en) begin
            if (if_a.Valid_Out) begin
               if (want_first) begin
                  check("first_latency", 32'(cyc), 32'(first_edge + 2));
                  want_first = 1'b0;
               end
               if (exp_q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected_output: got %h want none (cycle %0d)", if_a.Data_Out, cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("data_out", if_a.Data_Out, e[31:0]);
                  check("frame_done", 32'(if_a.Frame_Done), 32'(e[32]));
               end
            end else begin
               check("frame_done_idle", 32'(if_a.Frame_Done), 32'd0);
            end
         end
      end
   endtask

   initial begin
      int fd0;
      if_a.Data_In = '0; if_a.Valid_In = 1'b0;
      if_b.Data_In = '0; if_b.Valid_In = 1'b0;
`ifdef PAD_STREAM_PAD_VALUE_EN
      if_a.Pad_Value = PADV;
      if_b.Pad_Value = PADV;
`endif
      fork
         forever begin @(posedge clk); cyc++; end
         monitor();
         begin
            // reset state
            repeat (2) @(negedge clk);
            check("rst_valid_a", 32'(if_a.Valid_Out), 32'd0);
            check("rst_data_a", if_a.Data_Out, 32'd0);
            check("rst_fd_a", 32'(if_a.Frame_Done), 32'd0);
            check("rst_ovf_a", 32'(if_a.Overflow), 32'd0);
            check("rst_ovf_b", 32'(if_b.Overflow), 32'd0);
            @(posedge clk); #1 rst = 1'b1;
            idle_check("idle_after_reset");

            // basic frame
            fd0 = fd_seen;
            push_frame(1, 2, 3, 4);
            burst_a(1, 4, 1'b1);
            wait_drain(100);
            repeat (3) @(negedge clk);
            check("basic_fd_count", 32'(fd_seen - fd0), 32'd1);

            // sparse input, ~10 cycles apart
            fd0 = fd_seen;
            push_frame(11, 12, 13, 14);
            for (int i = 0; i < 4; i++) begin
               @(posedge clk); #1;
               if_a.Data_In = 32'(11 + i); if_a.Valid_In = 1'b1;
               @(posedge clk); #1 if_a.Valid_In = 1'b0;
               repeat (8) @(posedge clk);
               if (i < 3) begin
                  @(negedge clk);
                  check("sparse_stall", 32'(if_a.Valid_Out), 32'd0);
               end
            end
            wait_drain(100);
            repeat (3) @(negedge clk);
            check("sparse_fd_count", 32'(fd_seen - fd0), 32'd1);

            // back-to-back frames
            fd0 = fd_seen;
            push_frame(21, 22, 23, 24);
            push_frame(25, 26, 27, 28);
            burst_a(21, 8, 1'b0);
            wait_drain(200);
            repeat (3) @(negedge clk);
            check("b2b_fd_count", 32'(fd_seen - fd0), 32'd2);
            check("b2b_overflow", 32'(if_a.Overflow), 32'd0);

            // overflow on the small FIFO
            check("ovf_b_before", 32'(if_b.Overflow), 32'd0);
            burst_b(100, 16);
            repeat (5) @(negedge clk);
            check("ovf_b_set", 32'(if_b.Overflow), 32'd1);
            repeat (20) @(negedge clk);
            check("ovf_b_sticky", 32'(if_b.Overflow), 32'd1);

            // reset in the middle of a frame
            mon_en = 1'b0;
            burst_a(99, 1, 1'b0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("pre_reset_valid", 32'(if_a.Valid_Out), 32'd1);
            #2 rst = 1'b0;
            #1;
            check("midrst_valid", 32'(if_a.Valid_Out), 32'd0);
            check("midrst_data", if_a.Data_Out, 32'd0);
            check("midrst_fd", 32'(if_a.Frame_Done), 32'd0);
            check("midrst_ovf_b", 32'(if_b.Overflow), 32'd0);
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            exp_q.delete();
            want_first = 1'b0;
            mon_en = 1'b1;
            idle_check("idle_after_midrst");

            // clean frame after the discarded one
            fd0 = fd_seen;
            push_frame(31, 32, 33, 34);
            burst_a(31, 4, 1'b1);
            wait_drain(100);
            repeat (3) @(negedge clk);
            check("post_rst_fd_count", 32'(fd_seen - fd0), 32'd1);
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
